dbnc_sync: RTL and testbench

Input-conditioning stage placed directly upstream of the `l00` capture path inside `fixbnd`. It takes the asynchronous board inputs `a`, `b` and `c` and passes them through a two-flop synchronizer into the `clkx` domain. Each channel is then debounced with a stable-count filter. The block drives clean levels plus one-cycle rise/fall pulses to the capture stage.

---
 rtl/dbnc_sync.sv | 105 ++++++++++
 tb/tb_dbnc_sync.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dbnc_sync.sv
// dbnc_sync: two-flop synchronizer followed by a per-channel stable-count
// debounce filter. Drives clean levels plus one-cycle rise/fall pulses.
module dbnc_sync #(
  parameter int NCH    = 3,
  parameter int STABLE = 50000,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [NCH-1:0] raw_in,
  output logic [NCH-1:0] lvl_out,
  output logic [NCH-1:0] rise_out,
  output logic [NCH-1:0] fall_out,
  output logic           ready
);

  typedef enum logic [1:0] {
    INIT0 = 2'd0,
    INIT1 = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Count value on which the level is allowed to change.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE - 1);

  state_t         state;
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;

  // Two-flop synchronizer bringing the raw inputs into the clk domain.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Global init sequencer: two settle cycles, then filtering runs until reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= INIT0;
      ready <= 1'b0;
    end else begin
      case (state)
        INIT0:   state <= INIT1;
        INIT1: begin
          state <= RUN;
          ready <= 1'b1;
        end
        RUN:     state <= RUN;
        default: state <= INIT0;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi = gi + 1) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic             lvl;
      logic             rise;
      logic             fall;

      // Stable-count filter: a level change needs STABLE consecutive
      // disagreeing samples; one agreeing sample restarts the count.
      always_ff @(posedge clk) begin
        if (!resetn) begin
          cnt  <= '0;
          lvl  <= 1'b0;
          rise <= 1'b0;
          fall <= 1'b0;
        end else begin
          rise <= 1'b0;
          fall <= 1'b0;
          if (state == INIT1) begin
            // s2 still holds its reset zero on this edge, so the initial
            // level is taken from the first stage, which already carries
            // the input seen after reset release. No pulse on this load.
            lvl <= s1[gi];
            cnt <= '0;
          end else if (state == RUN) begin
            if (s2[gi] == lvl) begin
              cnt <= '0;
            end else if (cnt == CNT_LAST) begin
              lvl  <= s2[gi];
              cnt  <= '0;
              rise <= s2[gi];
              fall <= ~s2[gi];
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
      end

      assign lvl_out[gi]  = lvl;
      assign rise_out[gi] = rise;
      assign fall_out[gi] = fall;
    end
  endgenerate

endmodule

// File: tb/tb_dbnc_sync.sv
// tb_dbnc_sync: directed scenarios plus randomized stimulus for dbnc_sync,
// checked every cycle against a timestamp-based reference model.
module tb_dbnc_sync;

  localparam int NCH    = 3;
  localparam int STABLE = 4;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [NCH-1:0] raw_in = '0;
  logic [NCH-1:0] lvl_out;
  logic [NCH-1:0] rise_out;
  logic [NCH-1:0] fall_out;
  logic           ready;

  int checks = 0;
  int failures = 0;

  dbnc_sync #(
    .NCH(NCH),
    .STABLE(STABLE),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .raw_in(raw_in),
    .lvl_out(lvl_out),
    .rise_out(rise_out),
    .fall_out(fall_out),
    .ready(ready)
  );

  always #5 clk = ~clk;

  // Reference model. n counts edges since reset release. The filter sees the
  // raw input from two edges earlier. The initial level is the raw value
  // captured on the first edge after release. A channel changes level when
  // STABLE edges have passed since it last agreed (or last changed/loaded)
  // and it still disagrees.
  int             n = 0;
  logic [NCH-1:0] hist1 = '0;
  logic [NCH-1:0] hist2 = '0;
  logic [NCH-1:0] m_lvl = '0;
  logic [NCH-1:0] m_rise = '0;
  logic [NCH-1:0] m_fall = '0;
  logic           m_ready = 1'b0;
  int             since [NCH];

  always @(posedge clk) begin
    m_rise = '0;
    m_fall = '0;
    if (!resetn) begin
      n       = 0;
      hist1   = '0;
      hist2   = '0;
      m_lvl   = '0;
      m_ready = 1'b0;
    end else begin
      n = n + 1;
      if (n == 2) begin
        m_lvl   = hist1;
        m_ready = 1'b1;
        for (int i = 0; i < NCH; i++) since[i] = n;
      end else if (n >= 3) begin
        for (int i = 0; i < NCH; i++) begin
          if (hist2[i] == m_lvl[i]) begin
            since[i] = n;
          end else if (n - since[i] == STABLE) begin
            m_lvl[i] = hist2[i];
            if (hist2[i]) m_rise[i] = 1'b1;
            else          m_fall[i] = 1'b1;
            since[i] = n;
          end
        end
      end
      hist2 = hist1;
      hist1 = raw_in;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Drive inputs for k cycles, checking every output after each edge.
  task automatic cyc(input logic [NCH-1:0] r, input logic rn, input int k);
    for (int j = 0; j < k; j++) begin
      raw_in = r;
      resetn = rn;
      @(negedge clk);
      check("lvl_out", 32'(lvl_out), 32'(m_lvl));
      check("rise_out", 32'(rise_out), 32'(m_rise));
      check("fall_out", 32'(fall_out), 32'(m_fall));
      check("ready", 32'(ready), 32'(m_ready));
      $display("t=%0t rst_n=%0b raw=%b lvl=%b rise=%b fall=%b ready=%0b",
               $time, rn, r, lvl_out, rise_out, fall_out, ready);
    end
  endtask

  logic [NCH-1:0] cur;
  logic           rn;

  initial begin
    // reset and init with 101 held
    cyc(3'b101, 1'b0, 3);
    cyc(3'b101, 1'b1, 12);
    // clean fall then clean rise on channel 0
    cyc(3'b100, 1'b1, 10);
    cyc(3'b101, 1'b1, 10);
    // bounce reject on channel 1
    for (int k = 0; k < 5; k++) begin
      cyc(3'b111, 1'b1, 3);
      cyc(3'b101, 1'b1, 2);
    end
    cyc(3'b101, 1'b1, 6);
    // bounce then settle on channel 2
    cyc(3'b001, 1'b1, 2);
    cyc(3'b101, 1'b1, 1);
    cyc(3'b001, 1'b1, 10);
    // simultaneous channels
    cyc(3'b000, 1'b1, 10);
    cyc(3'b111, 1'b1, 10);
    cyc(3'b000, 1'b1, 10);
    // mid-count reset
    cyc(3'b001, 1'b1, 3);
    cyc(3'b001, 1'b0, 1);
    cyc(3'b001, 1'b1, 12);
    // randomized phase with occasional resets
    for (int k = 0; k < 400; k++) begin
      cur = NCH'($urandom_range(0, 7));
      rn  = ($urandom_range(0, 49) != 0);
      cyc(cur, rn, int'($urandom_range(1, 8)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
